// File: rtl/core_pkg.sv
// Shared integer-core definitions: memory access sizes, the MEM-stage state
// type, and the alignment rule used to reject misaligned accesses.
package core_pkg;

  // Access size encodings carried down the pipeline in mem_size
  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_D = 2'd3;

  // Bus handshake state of the memory stage
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // An access is misaligned when the low address bits inside its natural
  // size are non-zero; byte accesses can never be misaligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [2:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      MEM_H:   mis = off[0];
      MEM_W:   mis = |off[1:0];
      MEM_D:   mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the 64-bit data bus: byte enables and shifted write
// data for stores, lane extraction plus sign/zero extension for loads.
// Purely combinational; the store path and the load path are independent so
// the store side can work on the incoming instruction while the load side
// works on the latched in-flight access.
module lsu_align
  import core_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [2:0]  st_off_i,
  input  logic [63:0] store_data_i,
  input  logic [1:0]  ld_size_i,
  input  logic [2:0]  ld_off_i,
  input  logic        ld_unsigned_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  be_o,
  output logic [63:0] wdata_o,
  output logic [63:0] ld_data_o
);

  logic [7:0]  be_base;
  logic [63:0] ld_shifted;

  // Store side: size mask and data shifted into the addressed lanes
  always_comb begin
    // NOTE: every variable written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    be_base = 8'h01;
    case (st_size_i)
      MEM_B:   be_base = 8'h01;
      MEM_H:   be_base = 8'h03;
      MEM_W:   be_base = 8'h0F;
      MEM_D:   be_base = 8'hFF;
      default: be_base = 8'h01;
    endcase
    be_o    = be_base << st_off_i;
    wdata_o = store_data_i << {st_off_i, 3'b000};
  end

  // Load side: bring the addressed lanes down to bit 0, then extend
  always_comb begin
    ld_shifted = rdata_i >> {ld_off_i, 3'b000};
    ld_data_o  = ld_shifted;
    case (ld_size_i)
      MEM_B:   ld_data_o = ld_unsigned_i ? {56'd0, ld_shifted[7:0]}
                                         : {{56{ld_shifted[7]}}, ld_shifted[7:0]};
      MEM_H:   ld_data_o = ld_unsigned_i ? {48'd0, ld_shifted[15:0]}
                                         : {{48{ld_shifted[15]}}, ld_shifted[15:0]};
      MEM_W:   ld_data_o = ld_unsigned_i ? {32'd0, ld_shifted[31:0]}
                                         : {{32{ld_shifted[31]}}, ld_shifted[31:0]};
      default: ld_data_o = ld_shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV64 memory-access stage. Passes ALU results through to write-back, and
// runs loads/stores over a single-outstanding req/ack bus, stalling the front
// of the pipeline while an access is in flight. Holds the MEM/WB register.
module mem_stage
  import core_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] result_i,
  input  logic [4:0]        reg_write_addr_i,
  input  logic              reg_write_enable_i,
  input  logic              mem_valid_i,
  input  logic              mem_rw_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_unsigned_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [7:0]        bus_be_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [4:0]        wb_reg_addr_o,
  output logic              wb_reg_we_o,
  output logic              misaligned_o,
  output logic              stall_req_o
);

  mem_state_t        state_q, state_d;

  // Bus request registers, held stable for the whole BUSY period
  logic              bus_req_q,   bus_req_d;
  logic              bus_we_q,    bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
  logic [7:0]        bus_be_q,    bus_be_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

  // Latched view of the in-flight load, needed when the ack returns
  logic [2:0]        off_q,       off_d;
  logic [1:0]        size_q,      size_d;
  logic              uns_q,       uns_d;
  logic [4:0]        rd_q,        rd_d;
  logic              rd_we_q,     rd_we_d;

  // MEM/WB register
  logic [DATA_W-1:0] wb_data_q,   wb_data_d;
  logic [4:0]        wb_addr_q,   wb_addr_d;
  logic              wb_we_q,     wb_we_d;
  logic              mis_q,       mis_d;

  logic              stall_req;
  logic              in_misaligned;
  logic [7:0]        st_be;
  logic [DATA_W-1:0] st_wdata;
  logic [DATA_W-1:0] ld_data;

  assign in_misaligned = is_misaligned(mem_size_i, result_i[2:0]);

  lsu_align u_align (
    .st_size_i     (mem_size_i),
    .st_off_i      (result_i[2:0]),
    .store_data_i  (store_data_i),
    .ld_size_i     (size_q),
    .ld_off_i      (off_q),
    .ld_unsigned_i (uns_q),
    .rdata_i       (bus_rdata_i),
    .be_o          (st_be),
    .wdata_o       (st_wdata),
    .ld_data_o     (ld_data)
  );

  // Next-state, bus and write-back decisions for the IDLE/BUSY handshake
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    rd_d        = rd_q;
    rd_we_d     = rd_we_q;
    wb_data_d   = wb_data_q;
    wb_addr_d   = wb_addr_q;
    wb_we_d     = 1'b0;
    mis_d       = 1'b0;
    stall_req   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!mem_valid_i) begin
          // Plain ALU instruction: one-cycle pass-through to write-back
          wb_data_d = result_i;
          wb_addr_d = reg_write_addr_i;
          wb_we_d   = reg_write_enable_i;
        end else if (in_misaligned) begin
          // Rejected access: flag it, suppress the register write
          mis_d     = 1'b1;
          wb_addr_d = reg_write_addr_i;
        end else begin
          // Accept: freeze the front end now, issue the request next edge
          stall_req   = 1'b1;
          state_d     = BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_rw_i;
          bus_addr_d  = {result_i[ADDR_W-1:3], 3'b000};
          bus_be_d    = st_be;
          bus_wdata_d = st_wdata;
          off_d       = result_i[2:0];
          size_d      = mem_size_i;
          uns_d       = mem_unsigned_i;
          rd_d        = reg_write_addr_i;
          rd_we_d     = reg_write_enable_i;
        end
      end
      BUSY: begin
        if (!bus_ack_i) begin
          stall_req = 1'b1;
        end else begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            wb_data_d = ld_data;
            wb_addr_d = rd_q;
            wb_we_d   = rd_we_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      rd_q        <= '0;
      rd_we_q     <= 1'b0;
      wb_data_q   <= '0;
      wb_addr_q   <= '0;
      wb_we_q     <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rd_q        <= rd_d;
      rd_we_q     <= rd_we_d;
      wb_data_q   <= wb_data_d;
      wb_addr_q   <= wb_addr_d;
      wb_we_q     <= wb_we_d;
      mis_q       <= mis_d;
    end
  end

  assign bus_req_o     = bus_req_q;
  assign bus_we_o      = bus_we_q;
  assign bus_addr_o    = bus_addr_q;
  assign bus_be_o      = bus_be_q;
  assign bus_wdata_o   = bus_wdata_q;
  assign wb_data_o     = wb_data_q;
  assign wb_reg_addr_o = wb_addr_q;
  assign wb_reg_we_o   = wb_we_q;
  assign misaligned_o  = mis_q;
  assign stall_req_o   = stall_req;

endmodule
